rtc_access_scheduler: RTL and testbench

// Owns the single RTC parallel bus transaction engine (CS/RD/WR/A-D sequencer) and shares it among three requesters.
// The three requesters are: the post-reset init sequence, edit-mode register writes and a periodic time/timer scan read.

---
 rtl/rtc_access_scheduler.sv | 206 ++++++++++++++++++++
 tb/tb_rtc_access_scheduler.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_access_scheduler.sv
// Shares one RTC parallel-bus transaction engine among three requesters: the power-up init sequence,
// edit-mode writes and a periodic nine-register scan read. Read-back bytes are held as BCD fields.
`timescale 1ns/1ps
module rtc_access_scheduler #(
    parameter int          REFRESH_CYCLES = 100_000,
    parameter int          TIMEOUT_CYCLES = 1024,
    parameter logic [7:0]  INIT_CMD       = 8'h10
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       wr_req,
    input  logic [7:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic       wr_ack,
    output logic       eng_start,
    output logic       eng_rw,
    output logic [7:0] eng_addr,
    output logic [7:0] eng_wdata,
    input  logic       eng_done,
    input  logic [7:0] eng_rdata,
    output logic [7:0] seg,
    output logic [7:0] min,
    output logic [7:0] hora,
    output logic [7:0] dia,
    output logic [7:0] mes,
    output logic [7:0] anio,
    output logic [7:0] t_seg,
    output logic [7:0] t_min,
    output logic [7:0] t_hora,
    output logic       scan_valid,
    output logic       busy,
    output logic       timeout_err
);
    localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        INIT_ISSUE, INIT_WAIT, IDLE, WR_ISSUE, WR_WAIT, RD_ISSUE, RD_WAIT
    } state_t;

    state_t          state_reg, state_next;
    logic            run_reg;
    logic            init_step_reg;
    logic [3:0]      scan_idx_reg;
    logic            scan_pend_reg;
    logic            last_wr_reg;
    logic [RW-1:0]   refresh_cnt_reg;
    logic [TW-1:0]   wait_cnt_reg;
    logic            timeout_err_reg;
    logic            scan_valid_reg;
    logic            rw_reg;
    logic [7:0]      addr_reg;
    logic [7:0]      wdata_reg;
    logic [7:0]      field_reg [9];
    logic [8:0]      field_load;

    logic wait_st, tmo, finish, rd_done, refresh_wrap;

    function automatic logic [7:0] scan_addr(input logic [3:0] idx);
        case (idx)
            4'd0:    return 8'h21;
            4'd1:    return 8'h22;
            4'd2:    return 8'h23;
            4'd3:    return 8'h24;
            4'd4:    return 8'h25;
            4'd5:    return 8'h26;
            4'd6:    return 8'h41;
            4'd7:    return 8'h42;
            4'd8:    return 8'h43;
            default: return 8'h21;
        endcase
    endfunction

    assign wait_st      = (state_reg == INIT_WAIT) || (state_reg == WR_WAIT) || (state_reg == RD_WAIT);
    assign tmo          = wait_st && !eng_done && (wait_cnt_reg == TW'(TIMEOUT_CYCLES - 1));
    assign finish       = wait_st && (eng_done || tmo);
    assign rd_done      = (state_reg == RD_WAIT) && eng_done;
    assign refresh_wrap = (refresh_cnt_reg == RW'(REFRESH_CYCLES - 1));

    // run_reg holds off the first init launch until the cycle after reset is released.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg       <= INIT_ISSUE;
            run_reg         <= 1'b0;
            init_step_reg   <= 1'b0;
            scan_idx_reg    <= '0;
            scan_pend_reg   <= 1'b0;
            last_wr_reg     <= 1'b0;
            refresh_cnt_reg <= '0;
            wait_cnt_reg    <= '0;
            timeout_err_reg <= 1'b0;
            scan_valid_reg  <= 1'b0;
            rw_reg          <= 1'b0;
            addr_reg        <= '0;
            wdata_reg       <= '0;
        end else begin
            state_reg       <= state_next;
            run_reg         <= 1'b1;
            scan_valid_reg  <= 1'b0;
            refresh_cnt_reg <= refresh_wrap ? '0 : refresh_cnt_reg + 1'b1;
            wait_cnt_reg    <= (wait_st && !finish) ? wait_cnt_reg + 1'b1 : '0;
            if (tmo)
                timeout_err_reg <= 1'b1;
            if (state_reg == INIT_WAIT && finish)
                init_step_reg <= 1'b1;
            if (state_next == WR_ISSUE && state_reg == IDLE)
                last_wr_reg <= 1'b1;
            else if (state_next == RD_ISSUE && state_reg == IDLE)
                last_wr_reg <= 1'b0;
            if (eng_start) begin
                rw_reg    <= eng_rw;
                addr_reg  <= eng_addr;
                wdata_reg <= eng_wdata;
            end
            // Completing the last field clears the pending flag, swallowing a wrap in that same cycle.
            if (rd_done && scan_idx_reg == 4'd8) begin
                scan_idx_reg   <= '0;
                scan_pend_reg  <= 1'b0;
                scan_valid_reg <= 1'b1;
            end else begin
                if (rd_done)
                    scan_idx_reg <= scan_idx_reg + 1'b1;
                if (refresh_wrap)
                    scan_pend_reg <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            INIT_ISSUE: if (run_reg) state_next = INIT_WAIT;
            INIT_WAIT:  if (finish) state_next = init_step_reg ? IDLE : INIT_ISSUE;
            IDLE: begin
                if (wr_req && !(last_wr_reg && scan_pend_reg))
                    state_next = WR_ISSUE;
                else if (scan_pend_reg)
                    state_next = RD_ISSUE;
            end
            WR_ISSUE:   state_next = WR_WAIT;
            WR_WAIT:    if (finish) state_next = IDLE;
            RD_ISSUE:   state_next = RD_WAIT;
            RD_WAIT:    if (finish) state_next = IDLE;
            default:    state_next = IDLE;
        endcase
    end

    always_comb begin
        eng_start = 1'b0;
        eng_rw    = rw_reg;
        eng_addr  = addr_reg;
        eng_wdata = wdata_reg;
        wr_ack    = 1'b0;
        busy      = run_reg && (state_reg != IDLE);
        case (state_reg)
            INIT_ISSUE: if (run_reg) begin
                eng_start = 1'b1;
                eng_rw    = 1'b0;
                eng_addr  = 8'h02;
                eng_wdata = init_step_reg ? 8'h00 : INIT_CMD;
            end
            WR_ISSUE: begin
                eng_start = 1'b1;
                eng_rw    = 1'b0;
                eng_addr  = wr_addr;
                eng_wdata = wr_data;
            end
            WR_WAIT:    wr_ack = eng_done;
            RD_ISSUE: begin
                eng_start = 1'b1;
                eng_rw    = 1'b1;
                eng_addr  = scan_addr(scan_idx_reg);
                eng_wdata = 8'h00;
            end
            default: ;
        endcase
    end

    generate
        for (genvar gi = 0; gi < 9; gi++) begin : g_load
            assign field_load[gi] = rd_done && (scan_idx_reg == 4'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < 9; i++) begin
            if (!reset_n)
                field_reg[i] <= '0;
            else if (field_load[i])
                field_reg[i] <= eng_rdata;
        end
    end

    assign seg         = field_reg[0];
    assign min         = field_reg[1];
    assign hora        = field_reg[2];
    assign dia         = field_reg[3];
    assign mes         = field_reg[4];
    assign anio        = field_reg[5];
    assign t_seg       = field_reg[6];
    assign t_min       = field_reg[7];
    assign t_hora      = field_reg[8];
    assign scan_valid  = scan_valid_reg;
    assign timeout_err = timeout_err_reg;

endmodule

// File: tb/tb_rtc_access_scheduler.sv
// Bench for rtc_access_scheduler: a behavioural RTC engine with register memory, an event log of
// grants/acks/scan completions, and directed steps with randomized data and engine latency.
`timescale 1ns/1ps
module tb_rtc_access_scheduler;
    localparam int REFRESH = 300;
    localparam int TMO     = 40;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       wr_req = 1'b0;
    logic [7:0] wr_addr = 8'h00;
    logic [7:0] wr_data = 8'h00;
    logic       wr_ack, eng_start, eng_rw;
    logic [7:0] eng_addr, eng_wdata;
    logic       eng_done = 1'b0;
    logic [7:0] eng_rdata = 8'h00;
    logic [7:0] seg, min, hora, dia, mes, anio, t_seg, t_min, t_hora;
    logic       scan_valid, busy, timeout_err;

    always #5 clk = ~clk;

    rtc_access_scheduler #(
        .REFRESH_CYCLES(REFRESH),
        .TIMEOUT_CYCLES(TMO),
        .INIT_CMD(8'h10)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .eng_start(eng_start), .eng_rw(eng_rw), .eng_addr(eng_addr), .eng_wdata(eng_wdata),
        .eng_done(eng_done), .eng_rdata(eng_rdata),
        .seg(seg), .min(min), .hora(hora), .dia(dia), .mes(mes), .anio(anio),
        .t_seg(t_seg), .t_min(t_min), .t_hora(t_hora),
        .scan_valid(scan_valid), .busy(busy), .timeout_err(timeout_err)
    );

    typedef struct {
        byte        kind;
        logic [7:0] addr;
        logic [7:0] data;
    } ev_t;

    ev_t        act_log [$];
    ev_t        exp_log [$];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] mem [256];
    logic [7:0] exp_field [9];
    logic [7:0] scan_tab [9]  = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h41, 8'h42, 8'h43};
    logic [7:0] spec_vals [9] = '{8'h59, 8'h30, 8'h12, 8'h31, 8'h12, 8'h17, 8'h05, 8'h04, 8'h03};
    logic [7:0] fld [9];
    logic [93:0] all_out;
    int         lat_fixed = 3;
    bit         hang = 1'b0;

    assign fld[0] = seg;   assign fld[1] = min;   assign fld[2] = hora;
    assign fld[3] = dia;   assign fld[4] = mes;   assign fld[5] = anio;
    assign fld[6] = t_seg; assign fld[7] = t_min; assign fld[8] = t_hora;
    assign all_out = {wr_ack, eng_start, eng_rw, eng_addr, eng_wdata, seg, min, hora, dia, mes, anio,
                      t_seg, t_min, t_hora, scan_valid, busy, timeout_err};

    function automatic ev_t mk(input byte k, input logic [7:0] a, input logic [7:0] d);
        ev_t e;
        e.kind = k;
        e.addr = a;
        e.data = d;
        return e;
    endfunction

    // Engine model: register file, done after a programmable latency, optional hang on reads.
    bit         e_active = 1'b0;
    int         e_cnt = 0;
    logic       e_rw = 1'b0;
    logic [7:0] e_addr = 8'h00;
    always @(posedge clk) begin
        #1;
        if (!reset_n) begin
            e_active = 1'b0;
            eng_done = 1'b0;
        end else begin
            eng_done = 1'b0;
            if (e_active) begin
                e_cnt--;
                if (e_cnt == 0) begin
                    e_active = 1'b0;
                    eng_done = 1'b1;
                    if (e_rw) begin
                        eng_rdata = mem[e_addr];
                        for (int i = 0; i < 9; i++)
                            if (scan_tab[i] == e_addr) exp_field[i] = mem[e_addr];
                    end
                end
            end
            if (eng_start) begin
                e_rw   = eng_rw;
                e_addr = eng_addr;
                if (!eng_rw) mem[eng_addr] = eng_wdata;
                if (!(hang && eng_rw)) begin
                    e_active = 1'b1;
                    e_cnt    = (lat_fixed > 0) ? lat_fixed : int'($urandom_range(1, 5));
                end
            end
        end
    end

    always @(posedge clk) begin
        #2;
        if (reset_n) begin
            if (eng_start)  act_log.push_back(mk(eng_rw ? "R" : "W", eng_addr, eng_rw ? 8'h00 : eng_wdata));
            if (wr_ack)     act_log.push_back(mk("A", 8'h00, 8'h00));
            if (scan_valid) act_log.push_back(mk("V", 8'h00, 8'h00));
        end
    end

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_log(input string tag);
        chk({tag, "_len"}, 96'(act_log.size()), 96'(exp_log.size()));
        for (int i = 0; i < exp_log.size() && i < act_log.size(); i++)
            chk($sformatf("%s_ev%0d", tag, i), {act_log[i].kind, act_log[i].addr, act_log[i].data},
                {exp_log[i].kind, exp_log[i].addr, exp_log[i].data});
    endtask

    task automatic check_fields(input string tag);
        for (int i = 0; i < 9; i++)
            chk($sformatf("%s_f%0d", tag, i), 96'(fld[i]), 96'(exp_field[i]));
    endtask

    task automatic wait_valid(input string tag, input int bound);
        int n = 0;
        while (scan_valid !== 1'b1 && n < bound) begin @(negedge clk); n++; end
        chk(tag, 96'(scan_valid), 96'(1));
    endtask

    task automatic wait_ack(input string tag, input int bound);
        int n = 0;
        while (wr_ack !== 1'b1 && n < bound) begin @(negedge clk); n++; end
        chk(tag, 96'(wr_ack), 96'(1));
    endtask

    task automatic wait_idle(input string tag, input int bound);
        int n = 0;
        while (busy !== 1'b0 && n < bound) begin @(negedge clk); n++; end
        chk(tag, 96'(busy), 96'(0));
    endtask

    task automatic wait_start(input string tag, input logic rw, input logic [7:0] addr, input int bound);
        int n = 0;
        while (!(eng_start === 1'b1 && eng_rw === rw && eng_addr === addr) && n < bound) begin
            @(negedge clk); n++;
        end
        chk(tag, {eng_start, eng_rw, eng_addr}, {1'b1, rw, addr});
    endtask

    task automatic init_log_check(input string tag);
        exp_log.delete();
        exp_log.push_back(mk("W", 8'h02, 8'h10));
        exp_log.push_back(mk("W", 8'h02, 8'h00));
        check_log(tag);
    endtask

    task automatic shuffle_scan_regs();
        for (int i = 0; i < 9; i++) mem[scan_tab[i]] = 8'($urandom);
    endtask

    initial begin
        int n, first_r, nreads, viol, nv;
        byte prev;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 9; i++) begin
            mem[scan_tab[i]] = spec_vals[i];
            exp_field[i]     = 8'h00;
        end

        // Reset state, then the two init writes with a 3-cycle engine.
        repeat (3) @(negedge clk);
        chk("reset_outs", 96'(all_out), 96'(0));
        reset_n = 1'b1;
        @(negedge clk);
        chk("init_busy", 96'(busy), 96'(1));
        wait_idle("init_idle", 60);
        init_log_check("init");
        chk("init_no_tmo", 96'(timeout_err), 96'(0));
        act_log.delete();

        // First scan: nine reads in table order, one scan_valid.
        wait_valid("scan1_valid", 2 * REFRESH);
        exp_log.delete();
        for (int i = 0; i < 9; i++) exp_log.push_back(mk("R", scan_tab[i], 8'h00));
        exp_log.push_back(mk("V", 8'h00, 8'h00));
        check_log("scan1");
        for (int i = 0; i < 9; i++) chk($sformatf("scan1_spec_f%0d", i), 96'(fld[i]), 96'(spec_vals[i]));
        repeat (5) @(negedge clk);
        nv = 0;
        foreach (act_log[i]) if (act_log[i].kind == "V") nv++;
        chk("scan1_one_valid", 96'(nv), 96'(1));

        // Write raised while the read of 8'h24 is in flight.
        lat_fixed = 0;
        shuffle_scan_regs();
        act_log.delete();
        wait_start("mid_rd24", 1'b1, 8'h24, 2 * REFRESH);
        wr_addr = 8'h22; wr_data = 8'h45; wr_req = 1'b1;
        wait_ack("mid_ack", 50);
        wr_req = 1'b0;
        wait_valid("mid_valid", 200);
        exp_log.delete();
        for (int i = 0; i < 4; i++) exp_log.push_back(mk("R", scan_tab[i], 8'h00));
        exp_log.push_back(mk("W", 8'h22, 8'h45));
        exp_log.push_back(mk("A", 8'h00, 8'h00));
        for (int i = 4; i < 9; i++) exp_log.push_back(mk("R", scan_tab[i], 8'h00));
        exp_log.push_back(mk("V", 8'h00, 8'h00));
        check_log("mid");
        check_fields("mid");

        // Idle writes: eng_start one cycle after the request, ack in the done cycle.
        for (int k = 0; k < 4; k++) begin
            wr_addr = 8'($urandom); wr_data = 8'($urandom); wr_req = 1'b1;
            @(negedge clk);
            chk($sformatf("wr%0d_start", k), {eng_start, eng_rw, eng_addr, eng_wdata},
                {1'b1, 1'b0, wr_addr, wr_data});
            wait_ack($sformatf("wr%0d_ack", k), 20);
            chk($sformatf("wr%0d_ack_done", k), 96'(eng_done), 96'(1));
            wr_req = 1'b0;
            @(negedge clk);
            chk($sformatf("wr%0d_ack_pulse", k), 96'(wr_ack), 96'(0));
        end

        // Held write request during a scan: grants alternate.
        wait_valid("pre_starve_valid", 2 * REFRESH);
        shuffle_scan_regs();
        act_log.delete();
        wr_addr = 8'($urandom); wr_data = 8'($urandom); wr_req = 1'b1;
        @(negedge clk);
        n = 0;
        while (scan_valid !== 1'b1 && n < 3 * REFRESH) begin
            @(negedge clk); n++;
            if (wr_ack === 1'b1) begin wr_addr = 8'($urandom); wr_data = 8'($urandom); end
        end
        wr_req = 1'b0;
        chk("starve_valid", 96'(scan_valid), 96'(1));
        first_r = -1; nreads = 0; viol = 0; prev = 0;
        foreach (act_log[i]) begin
            if (act_log[i].kind == "V") break;
            if (act_log[i].kind == "R" || act_log[i].kind == "W") begin
                if (act_log[i].kind == "R" && first_r < 0) first_r = i;
                if (first_r >= 0) begin
                    if (prev == act_log[i].kind) viol++;
                    prev = act_log[i].kind;
                    if (act_log[i].kind == "R") nreads++;
                end
            end
        end
        chk("starve_reads", 96'(nreads), 96'(9));
        chk("starve_alternate", 96'(viol), 96'(0));
        check_fields("starve");

        // Read that never completes: timeout, field kept, same address retried.
        shuffle_scan_regs();
        hang = 1'b1;
        wait_start("hang_rd21", 1'b1, 8'h21, 2 * REFRESH);
        n = 0;
        while (timeout_err !== 1'b1 && n < TMO + 10) begin @(negedge clk); n++; end
        chk("tmo_set", 96'(timeout_err), 96'(1));
        chk("tmo_latency", 96'(n >= TMO && n <= TMO + 2), 96'(1));
        chk("tmo_field_kept", 96'(seg), 96'(exp_field[0]));
        hang = 1'b0;
        wait_start("tmo_retry_rd21", 1'b1, 8'h21, 10);
        wait_valid("tmo_valid", 200);
        check_fields("tmo");
        chk("tmo_sticky", 96'(timeout_err), 96'(1));

        // Reset in the middle of a write wait.
        lat_fixed = 8;
        wr_addr = 8'($urandom); wr_data = 8'($urandom); wr_req = 1'b1;
        wait_start("rst_wr_start", 1'b0, wr_addr, 10);
        @(negedge clk);
        reset_n = 1'b0; wr_req = 1'b0;
        @(negedge clk);
        chk("midwr_reset_outs", 96'(all_out), 96'(0));
        @(negedge clk);
        lat_fixed = 3;
        act_log.delete();
        reset_n = 1'b1;
        @(negedge clk);
        wait_idle("reinit_idle", 60);
        init_log_check("reinit");
        chk("reinit_no_tmo", 96'(timeout_err), 96'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog observed=no_finish expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
